// File: rtl/ram_sdp_burst_reader.sv
// Burst read sequencer for ram_sdp: issues reads under a credit limit, tracks the
// RAM read latency with a tag pipe and returns the data as a ready/valid stream.
module ram_sdp_burst_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);

  localparam int PTR_W  = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CNT_W  = $clog2(BUF_DEPTH + 1);
  localparam int USED_W = $clog2(BUF_DEPTH + RD_LATENCY + 1);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 2) begin : g_bad_latency
      $fatal(1, "RD_LATENCY must be 1 or 2");
    end
    if (BUF_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
      $fatal(1, "BUF_DEPTH must be at least RD_LATENCY+2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
  logic [LEN_WIDTH-1:0]  remaining_reg, remaining_next;
  logic [LEN_WIDTH-1:0]  beats_left_reg, beats_left_next;
  logic [RD_LATENCY-1:0] tag_reg, tag_next;
  logic [USED_W-1:0]     tag_count, used;
  logic                  issue;

  logic [DATA_WIDTH-1:0] fifo_mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg, fifo_count_next;
  logic                  fifo_wr, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Tag pipe mirrors the RAM pipeline; a 1 marks a slot carrying a real read.
  assign tag_next[0] = issue;
  generate
    for (genvar gi = 1; gi < RD_LATENCY; gi++) begin : g_tag
      assign tag_next[gi] = tag_reg[gi-1];
    end
  endgenerate

  always_comb begin
    tag_count = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      tag_count = tag_count + USED_W'(tag_reg[i]);
    end
  end

  assign used        = tag_count + USED_W'(fifo_count_reg);
  assign fifo_wr     = tag_reg[RD_LATENCY-1];
  assign out_valid   = (fifo_count_reg != '0);
  assign out_data    = fifo_mem[rd_ptr_reg];
  assign out_last    = out_valid && (beats_left_reg == LEN_WIDTH'(1));
  assign pop         = out_valid && out_ready;
  assign ram_rd_addr = addr_reg;
  assign busy        = (state_reg != IDLE);

  always_comb begin
    state_next      = state_reg;
    addr_next       = addr_reg;
    remaining_next  = remaining_reg;
    beats_left_next = beats_left_reg;
    cmd_ready       = 1'b0;
    issue           = 1'b0;
    ram_rd_en       = 1'b0;
    if (pop) begin
      beats_left_next = beats_left_reg - LEN_WIDTH'(1);
    end
    case (state_reg)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid && cmd_len != '0) begin
          addr_next       = cmd_addr;
          remaining_next  = cmd_len;
          beats_left_next = cmd_len;
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        ram_rd_en = 1'b1;
        // Credit only counts reads already in flight or buffered; a same-cycle pop is ignored.
        if (remaining_reg != '0 && used < USED_W'(BUF_DEPTH)) begin
          issue          = 1'b1;
          addr_next      = addr_reg + ADDR_WIDTH'(1);
          remaining_next = remaining_reg - LEN_WIDTH'(1);
          if (remaining_reg == LEN_WIDTH'(1)) begin
            state_next = DRAIN;
          end
        end
      end
      DRAIN: begin
        ram_rd_en = |tag_reg;
        if (pop && out_last) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fifo_count_next = fifo_count_reg;
    if (fifo_wr && !pop) begin
      fifo_count_next = fifo_count_reg + CNT_W'(1);
    end else if (!fifo_wr && pop) begin
      fifo_count_next = fifo_count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      remaining_reg  <= '0;
      beats_left_reg <= '0;
      tag_reg        <= '0;
    end else begin
      state_reg      <= state_next;
      addr_reg       <= addr_next;
      remaining_reg  <= remaining_next;
      beats_left_reg <= beats_left_next;
      if (ram_rd_en) begin
        tag_reg <= tag_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        fifo_mem[i] <= '0;
      end
    end else begin
      fifo_count_reg <= fifo_count_next;
      if (fifo_wr) begin
        fifo_mem[wr_ptr_reg] <= ram_rd_data;
        wr_ptr_reg           <= ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_reg <= ptr_inc(rd_ptr_reg);
      end
    end
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(fifo_wr && fifo_count_reg == CNT_W'(BUF_DEPTH)));

endmodule

// File: tb/tb_ram_sdp_burst_reader.sv
// Scoreboard bench: two reader instances (RD_LATENCY 2/BUF 4 and RD_LATENCY 1/BUF 3)
// each fed by a behavioural ram_sdp; expected beats come from the burst rule on mem[].
module tb_ram_sdp_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid [2];
  logic        cmd_ready [2];
  logic [9:0]  cmd_addr [2];
  logic [10:0] cmd_len [2];
  logic        ram_rd_en [2];
  logic [9:0]  ram_rd_addr [2];
  logic [15:0] ram_rd_data [2];
  logic        out_valid [2];
  logic        out_ready [2];
  logic [15:0] out_data [2];
  logic        out_last [2];
  logic        busy [2];

  logic [15:0] mem [1024];
  logic [17:0] exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          popped [2];
  int          lasts [2];
  bit          rdy_on;

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_inst
      localparam int LAT = (gi == 0) ? 2 : 1;
      localparam int DEP = (gi == 0) ? 4 : 3;
      logic [15:0] rd_q, rd_o;
      always @(posedge clk) begin
        if (ram_rd_en[gi]) begin
          rd_q <= mem[ram_rd_addr[gi]];
          rd_o <= rd_q;
        end
      end
      assign ram_rd_data[gi] = (LAT == 1) ? rd_q : rd_o;

      ram_sdp_burst_reader #(
        .DATA_WIDTH(16), .ADDR_WIDTH(10), .LEN_WIDTH(11),
        .RD_LATENCY(LAT), .BUF_DEPTH(DEP)
      ) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid[gi]), .cmd_ready(cmd_ready[gi]),
        .cmd_addr(cmd_addr[gi]), .cmd_len(cmd_len[gi]),
        .ram_rd_en(ram_rd_en[gi]), .ram_rd_addr(ram_rd_addr[gi]),
        .ram_rd_data(ram_rd_data[gi]),
        .out_valid(out_valid[gi]), .out_ready(out_ready[gi]),
        .out_data(out_data[gi]), .out_last(out_last[gi]), .busy(busy[gi])
      );
    end
  endgenerate

  // Monitor: every pop is compared with the head of the scoreboard.
  always @(negedge clk) begin
    logic [17:0] e;
    for (int k = 0; k < 2; k++) begin
      if (rst_n && out_valid[k] && out_ready[k]) begin
        checks++;
        $display("beat inst=%0d data=%h last=%b", k, out_data[k], out_last[k]);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_extra inst=%0d: got data=%h last=%b, required no beat",
                   k, out_data[k], out_last[k]);
        end else begin
          e = exp_q.pop_front();
          if (e != {k[0], out_last[k], out_data[k]}) begin
            errors++;
            $display("FAIL beat inst=%0d: got inst/last/data=%0d/%b/%h, required %0d/%b/%h",
                     k, k, out_last[k], out_data[k], e[17], e[16], e[15:0]);
          end
        end
        popped[k]++;
        if (out_last[k]) lasts[k]++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send_cmd(input int k, input logic [9:0] a, input logic [10:0] l);
    int n;
    logic [9:0] ai;
    n = 0;
    cmd_valid[k] = 1'b1;
    cmd_addr[k]  = a;
    cmd_len[k]   = l;
    @(negedge clk);
    while (!cmd_ready[k] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_accept_timeout", {31'd0, cmd_ready[k]}, 32'd1);
    $display("cmd inst=%0d addr=%h len=%0d", k, a, l);
    for (int i = 0; i < int'(l); i++) begin
      ai = a + 10'(i);
      exp_q.push_back({k[0], (i == int'(l) - 1), mem[ai]});
    end
    @(posedge clk);
    #1;
    cmd_valid[k] = 1'b0;
  endtask

  task automatic wait_drain(input int k);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy[k]) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", exp_q.size() + {31'd0, busy[k]}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic(input int k, input int lat);
    int n, cnt;
    out_ready[k] = 1'b1;
    send_cmd(k, 10'h000, 11'd8);
    n = 1;
    @(negedge clk);
    while (!out_valid[k] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("first_beat_latency", n, lat + 2);
    cnt = 1;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      if (out_valid[k]) cnt++;
    end
    chk("consecutive_beats", cnt, 8);
    chk("cmd_ready_during_last", {31'd0, cmd_ready[k]}, 32'd0);
    @(negedge clk);
    chk("cmd_ready_after_last", {31'd0, cmd_ready[k]}, 32'd1);
    wait_drain(k);
  endtask

  task automatic test_stall();
    int n, p0;
    logic [9:0] issued;
    out_ready[0] = 1'b0;
    p0 = popped[0];
    send_cmd(0, 10'h000, 11'd8);
    n = 0;
    @(negedge clk);
    while (!out_valid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 12; i++) begin
      issued = ram_rd_addr[0] - 10'h000;
      chk("stall_frozen_data", {15'd0, out_valid[0], out_data[0]}, {15'd0, 1'b1, 16'h1000});
      chk("stall_credit_limit", {31'd0, (int'(issued) - (popped[0] - p0)) <= 4}, 32'd1);
      @(negedge clk);
    end
    issued = ram_rd_addr[0] - 10'h000;
    chk("stall_issued_reads", {22'd0, issued}, 32'd4);
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    wait_drain(0);
  endtask

  task automatic test_wrap();
    logic [9:0] seen [$];
    logic [9:0] exp_a [4];
    int n;
    exp_a = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
    out_ready[0] = 1'b1;
    send_cmd(0, 10'h3FE, 11'd4);
    n = 0;
    while (busy[0] && n < 100) begin
      @(negedge clk);
      if (ram_rd_en[0] && (seen.size() == 0 || seen[$] != ram_rd_addr[0]))
        seen.push_back(ram_rd_addr[0]);
      n++;
    end
    chk("wrap_addr_count", {31'd0, seen.size() >= 4}, 32'd1);
    for (int i = 0; i < 4 && i < seen.size(); i++) begin
      chk("wrap_addr_seq", {22'd0, seen[i]}, {22'd0, exp_a[i]});
    end
    wait_drain(0);
  endtask

  task automatic test_zero();
    send_cmd(0, 10'h010, 11'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("zero_len_idle", {28'd0, ram_rd_en[0], out_valid[0], busy[0], cmd_ready[0]},
          32'b0001);
    end
    @(posedge clk);
    #1;
    send_cmd(0, 10'h020, 11'd2);
    wait_drain(0);
  endtask

  task automatic test_reset();
    int n, p0;
    out_ready[0] = 1'b1;
    p0 = popped[0];
    send_cmd(0, 10'h040, 11'd16);
    n = 0;
    while ((popped[0] - p0) < 3 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("reset_wait_timeout", {31'd0, n < 100}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("reset_out_valid", {31'd0, out_valid[0]}, 32'd0);
    chk("reset_rd_en", {31'd0, ram_rd_en[0]}, 32'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post_reset_busy", {31'd0, busy[0]}, 32'd0);
    chk("post_reset_cmd_ready", {31'd0, cmd_ready[0]}, 32'd1);
    p0 = popped[0];
    repeat (10) @(negedge clk);
    chk("no_stray_beats", popped[0] - p0, 0);
    @(posedge clk);
    #1;
    send_cmd(0, 10'h007, 11'd2);
    wait_drain(0);
  endtask

  task automatic test_random(input int k, input int nb);
    int nz, l0;
    nz = 0;
    l0 = lasts[k];
    rdy_on = 1'b1;
    fork
      begin
        for (int b = 0; b < nb; b++) begin
          logic [10:0] len;
          logic [9:0]  a;
          len = 11'($urandom_range(0, 12));
          a   = 10'($urandom_range(0, 1023));
          if (len != 0) nz++;
          send_cmd(k, a, len);
        end
        wait_drain(k);
        rdy_on = 1'b0;
      end
      begin
        while (rdy_on) begin
          out_ready[k] = 1'($urandom_range(0, 1));
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready[k] = 1'b1;
    chk("last_per_burst", lasts[k] - l0, nz);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = (i < 8) ? 16'(16'h1000 + i) : 16'($urandom);
    end
    for (int k = 0; k < 2; k++) begin
      cmd_valid[k] = 1'b0;
      cmd_addr[k]  = '0;
      cmd_len[k]   = '0;
      out_ready[k] = 1'b1;
      popped[k]    = 0;
      lasts[k]     = 0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("reset_state", {23'd0, out_valid[k], out_last[k], ram_rd_en[k], busy[k],
                          cmd_ready[k], 4'd0}, 32'b000010000);
      chk("reset_out_data", {16'd0, out_data[k]}, 32'd0);
      chk("reset_rd_addr", {22'd0, ram_rd_addr[k]}, 32'd0);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_basic(0, 2);
    test_basic(1, 1);
    test_stall();
    test_wrap();
    test_zero();
    test_reset();
    test_random(0, 10);
    test_random(1, 20);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
